clk_period_meter: RTL and testbench



---
 rtl/clk_meter_pkg.sv | 6 +
 rtl/sync_edge_detect.sv | 20 ++
 rtl/clk_period_meter.sv | 124 ++++++++++++
 tb/tb_clk_period_meter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_meter_pkg.sv
// clk_meter_pkg: shared state encoding and averaging constants for clk_period_meter.
package clk_meter_pkg;
  typedef enum logic {IDLE, MEASURE} state_t;
  localparam int AVG_LOG2 = 2;
  localparam int AVG_COUNT = 4;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: 2-flop synchronizer plus history flop, one-cycle pulse on each synchronized rising edge.
module sync_edge_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_rise
);
  logic [1:0] r_sync;
  logic       r_hist;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_sig};
      r_hist <= r_sync[1];
    end
  end
  assign o_rise = r_sync[1] & ~r_hist;
endmodule

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the period of an asynchronous slow clock in i_clk cycles, with stall timeout.
// Define CLK_METER_AVG_EN to report the truncated mean of every 4 periods instead of each period.
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_enable,
  input  logic                 i_sig_clk,
  output logic [CNT_WIDTH-1:0] o_period,
  output logic                 o_valid,
  output logic                 o_timeout
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] TO_CNT  = CNT_WIDTH'(TIMEOUT_CYCLES);

  state_t               r_state, w_state_n;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_n, r_period, w_period_n;
  logic                 r_valid, w_valid_n, r_timeout, w_timeout_n;
  logic                 w_rise;
`ifdef CLK_METER_AVG_EN
  logic [CNT_WIDTH+1:0] r_acc, w_acc_n, w_sum;
  logic [AVG_LOG2-1:0]  r_idx, w_idx_n;
  assign w_sum = r_acc + {2'b00, r_cnt};
`endif

  sync_edge_detect u_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_sig  (i_sig_clk),
    .o_rise (w_rise)
  );

  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_period_n  = r_period;
    w_valid_n   = 1'b0;
    w_timeout_n = r_timeout;
`ifdef CLK_METER_AVG_EN
    w_acc_n     = r_acc;
    w_idx_n     = r_idx;
`endif
    if (!i_enable) begin
      w_state_n   = IDLE;
      w_cnt_n     = '0;
      w_timeout_n = 1'b0;
`ifdef CLK_METER_AVG_EN
      w_acc_n     = '0;
      w_idx_n     = '0;
`endif
    end else if (r_state == IDLE) begin
      w_cnt_n = '0;
      if (w_rise) begin
        w_state_n   = MEASURE;
        w_cnt_n     = CNT_ONE;
        w_timeout_n = 1'b0;
      end
    end else if (w_rise) begin
      // an edge coinciding with the timeout count still completes a valid period
      w_cnt_n = CNT_ONE;
`ifdef CLK_METER_AVG_EN
      if (r_idx == AVG_LOG2'(AVG_COUNT - 1)) begin
        w_period_n = w_sum[CNT_WIDTH+1:AVG_LOG2];
        w_valid_n  = 1'b1;
        w_acc_n    = '0;
        w_idx_n    = '0;
      end else begin
        w_acc_n = w_sum;
        w_idx_n = r_idx + AVG_LOG2'(1);
      end
`else
      w_period_n = r_cnt;
      w_valid_n  = 1'b1;
`endif
    end else if (r_cnt == TO_CNT) begin
      w_state_n   = IDLE;
      w_cnt_n     = '0;
      w_timeout_n = 1'b1;
`ifdef CLK_METER_AVG_EN
      w_acc_n     = '0;
      w_idx_n     = '0;
`endif
    end else begin
      w_cnt_n = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_period  <= w_period_n;
      r_valid   <= w_valid_n;
      r_timeout <= w_timeout_n;
    end
  end

`ifdef CLK_METER_AVG_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
      r_idx <= '0;
    end else begin
      r_acc <= w_acc_n;
      r_idx <= w_idx_n;
    end
  end
`endif

  assign o_period  = r_period;
  assign o_valid   = r_valid;
  assign o_timeout = r_timeout;
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: table-driven and randomized checks of clk_period_meter against a period-list model.
module tb_clk_period_meter;
  localparam int CW = 16;
  localparam int TO = 100;

  logic          clk = 1'b0, rst_n = 1'b0, en = 1'b0, sig = 1'b0;
  logic [CW-1:0] period;
  logic          valid, timeout;
  int            n_vec = 0, n_err = 0;
  int            got_q[$], per_q[$], exp_q[$];
  logic          prev_valid = 1'b0;

  typedef struct {
    int   p_a;
    int   p_b;
    int   run;
    int   n;
    int   gap;
    logic exp_to;
  } vec_t;
  vec_t vecs[8];

  clk_period_meter #(.CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_enable (en),
    .i_sig_clk(sig),
    .o_period (period),
    .o_valid  (valid),
    .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (valid) begin
      got_q.push_back(int'(period));
      check("valid_back_to_back", int'(prev_valid), 0);
    end
    prev_valid = valid;
  end

  // Reference: each completed period is reported, or the mean of each group of 4 when averaging.
  task automatic finish_case(input string name);
    exp_q = {};
`ifdef CLK_METER_AVG_EN
    begin
      int s;
      s = 0;
      for (int i = 0; i < per_q.size(); i++) begin
        s += per_q[i];
        if (i % 4 == 3) begin
          exp_q.push_back(s / 4);
          s = 0;
        end
      end
    end
`else
    exp_q = per_q;
`endif
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_p%0d", name, i), got_q[i], exp_q[i]);
    got_q = {};
    per_q = {};
  endtask

  task automatic edge_then(input int p);
    sig = 1'b1;
    repeat (p / 2) @(negedge clk);
    sig = 1'b0;
    repeat (p - p / 2) @(negedge clk);
  endtask

  task automatic rearm();
    en  = 1'b0;
    sig = 1'b0;
    repeat (4) @(negedge clk);
    en = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    rearm();
    for (int i = 0; i < v.n; i++) begin
      int p;
      p = ((i / v.run) % 2) ? v.p_b : v.p_a;
      edge_then(p);
      per_q.push_back(p);
    end
    sig = 1'b1;
    repeat (v.gap) @(negedge clk);
    check({name, "_timeout"}, int'(timeout), int'(v.exp_to));
    finish_case(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    vec_t v;
    vecs[0] = '{10, 10, 1, 8, 5, 1'b0};
    vecs[1] = '{100, 100, 1, 4, 5, 1'b0};
    vecs[2] = '{9, 11, 1, 50, 5, 1'b0};
    vecs[3] = '{10, 11, 2, 4, 5, 1'b0};
    vecs[4] = '{2, 2, 1, 8, 5, 1'b0};
    vecs[5] = '{10, 10, 1, 4, 120, 1'b1};
    vecs[6] = '{3, 7, 1, 12, 5, 1'b0};
    vecs[7] = '{50, 99, 3, 8, 5, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_period", int'(period), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_timeout", int'(timeout), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 8; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    for (int k = 0; k < 6; k++) begin
      v.p_a    = $urandom_range(2, TO);
      v.p_b    = $urandom_range(2, TO);
      v.run    = $urandom_range(1, 3);
      v.n      = $urandom_range(4, 16);
      v.gap    = 5;
      v.exp_to = 1'b0;
      run_vec(v, $sformatf("rand%0d", k));
    end

    // stall: timeout latency, restart, second stall, cleared by disable
    rearm();
    sig = 1'b1;
    cyc = 0;
    while (!timeout && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("timeout_latency", cyc, TO + 3);
    check("timeout_no_valid", got_q.size(), 0);
    @(negedge clk);
    sig = 1'b0;
    repeat (3) @(negedge clk);
    sig = 1'b1;
    repeat (4) @(negedge clk);
    check("timeout_cleared_by_arm", int'(timeout), 0);
    check("arm_no_valid", got_q.size(), 0);
    sig = 1'b0;
    repeat (16) @(negedge clk);
    sig = 1'b1;
    per_q.push_back(20);
    repeat (5) @(negedge clk);
    finish_case("restart");
    repeat (120) @(negedge clk);
    check("timeout_again", int'(timeout), 1);
    en = 1'b0;
    repeat (2) @(negedge clk);
    check("timeout_cleared_by_disable", int'(timeout), 0);
    finish_case("stall");

    // asynchronous reset in the middle of a period
    rearm();
    edge_then(10);
    per_q.push_back(10);
    sig = 1'b1;
    repeat (5) @(negedge clk);
    finish_case("pre_reset");
    #3 rst_n = 1'b0;
    #1;
    check("async_reset_period", int'(period), 0);
    check("async_reset_valid", int'(valid), 0);
    check("async_reset_timeout", int'(timeout), 0);
    sig = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    edge_then(15);
    sig = 1'b1;
    per_q.push_back(15);
    repeat (5) @(negedge clk);
    finish_case("post_reset");

    // enable dropped for 3 cycles mid-period forces a re-arm
    rearm();
    sig = 1'b1;
    repeat (5) @(negedge clk);
    sig = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    edge_then(12);
    sig = 1'b1;
    per_q.push_back(12);
    repeat (5) @(negedge clk);
    finish_case("disable");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
